// File: rtl/dh_pkg.sv
// Shared definitions for the Diffie-Hellman modular exponentiation datapath:
// FSM states, default operand widths and the fixed-latency formula.
package dh_pkg;

  localparam int DH_W  = 32;
  localparam int DH_EW = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    LOOP   = 2'd2,
    FINISH = 2'd3
  } dh_state_e;

  // Cycles from the start-sampling edge to the edge that raises done.
  function automatic int dh_latency(input int w, input int ew);
    return (ew + 1) * (w + 1) + 1;
  endfunction

endpackage

// File: rtl/dh_modmult.sv
// Interleaved shift-add modular multiplier: prod = a*b mod p, MSB-first scan of a.
// Operands are read live during compute and must stay stable until rdy; b < p.
module dh_modmult #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] p,
  output logic         rdy,
  output logic [W-1:0] prod
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic [W-1:0]  r_q, r_d;

  logic [CW-1:0] idx_s;
  logic [W-1:0]  a_sh_s;
  logic [W+1:0]  p_ext_s, sum_s, sub1_s, sub2_s;

  assign rdy  = run_q && (cnt_q == '0);
  assign prod = r_q;

  // One shift-add step followed by up to two conditional subtractions; sum < 3p.
  always_comb begin
    idx_s   = cnt_q - CW'(1);
    a_sh_s  = a >> idx_s;
    p_ext_s = {2'b00, p};
    sum_s   = {1'b0, r_q, 1'b0} + (a_sh_s[0] ? {2'b00, b} : {(W+2){1'b0}});
    sub1_s  = (sum_s >= p_ext_s) ? (sum_s - p_ext_s) : sum_s;
    sub2_s  = (sub1_s >= p_ext_s) ? (sub1_s - p_ext_s) : sub1_s;
    cnt_d   = cnt_q;
    run_d   = run_q;
    r_d     = r_q;
    if (go) begin
      run_d = 1'b1;
      cnt_d = CW'(W);
      r_d   = '0;
    end else if (rdy) begin
      run_d = 1'b0;
    end else if (run_q) begin
      r_d   = W'(sub2_s);
      cnt_d = cnt_q - CW'(1);
    end else begin
      r_d   = r_q;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
      r_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
      r_q   <= r_d;
    end
  end

endmodule

// File: rtl/dh_modexp.sv
// Constant-time right-to-left square-and-multiply: result = base^exp mod mod.
// Optional DH_MODEXP_ERR_CHECK_EN rejects mod < 2 with err=1 and result=0.
module dh_modexp
  import dh_pkg::*;
#(
  parameter int W  = DH_W,
  parameter int EW = DH_EW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  base,
  input  logic [EW-1:0] exp,
  input  logic [W-1:0]  mod,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          err
);

  localparam int BW = $clog2(EW + 1);

  dh_state_e     state_q, state_d;
  logic [W-1:0]  base_q, base_d;
  logic [EW-1:0] exp_q, exp_d;
  logic [W-1:0]  mod_q, mod_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  sq_q, sq_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  result_q, result_d;

  logic          go_m_s, go_s_s, m_rdy_s, s_rdy_s;
  logic [W-1:0]  m_prod_s, s_prod_s, s_a_s, s_b_s;
  logic          bad_s, mod_bad_s;

`ifdef DH_MODEXP_ERR_CHECK_EN
  logic bad_q, bad_d;
  logic err_q, err_d;
  assign bad_s     = bad_q;
  assign mod_bad_s = (mod < W'(2));
  assign err       = err_q;
`else
  assign bad_s     = 1'b0;
  assign mod_bad_s = 1'b0;
  assign err       = 1'b0;
`endif

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

  // The squaring unit doubles as the base-reduction unit (base * 1 mod p).
  assign s_a_s = (state_q == REDUCE) ? base_q : sq_q;
  assign s_b_s = (state_q == REDUCE) ? W'(1) : sq_q;

  dh_modmult #(.W(W)) u_mul (
    .clk(clk), .rst(rst), .go(go_m_s), .a(acc_q), .b(sq_q), .p(mod_q),
    .rdy(m_rdy_s), .prod(m_prod_s)
  );

  dh_modmult #(.W(W)) u_sqr (
    .clk(clk), .rst(rst), .go(go_s_s), .a(s_a_s), .b(s_b_s), .p(mod_q),
    .rdy(s_rdy_s), .prod(s_prod_s)
  );

  // Sequencer: a result is consumed on the same edge that launches the next multiply.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    exp_d    = exp_q;
    mod_d    = mod_q;
    acc_d    = acc_q;
    sq_d     = sq_q;
    bit_d    = bit_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    go_m_s   = 1'b0;
    go_s_s   = 1'b0;
`ifdef DH_MODEXP_ERR_CHECK_EN
    bad_d    = bad_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base;
          exp_d   = exp;
          mod_d   = mod;
          acc_d   = W'(1);
          busy_d  = 1'b1;
          state_d = REDUCE;
          go_s_s  = !mod_bad_s;
`ifdef DH_MODEXP_ERR_CHECK_EN
          bad_d   = mod_bad_s;
          err_d   = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      REDUCE: begin
        if (bad_s) begin
          state_d = FINISH;
        end else if (s_rdy_s) begin
          sq_d    = s_prod_s;
          bit_d   = '0;
          go_m_s  = 1'b1;
          go_s_s  = 1'b1;
          state_d = LOOP;
        end else begin
          state_d = REDUCE;
        end
      end
      LOOP: begin
        if (s_rdy_s && m_rdy_s) begin
          sq_d  = s_prod_s;
          acc_d = exp_q[0] ? m_prod_s : acc_q;
          exp_d = exp_q >> 1;
          if (bit_q == BW'(EW - 1)) begin
            state_d = FINISH;
          end else begin
            bit_d  = bit_q + BW'(1);
            go_m_s = 1'b1;
            go_s_s = 1'b1;
          end
        end else begin
          state_d = LOOP;
        end
      end
      FINISH: begin
        result_d = bad_s ? '0 : acc_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
`ifdef DH_MODEXP_ERR_CHECK_EN
        err_d    = bad_q;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and handshake registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      exp_q    <= '0;
      mod_q    <= '0;
      acc_q    <= '0;
      sq_q     <= '0;
      bit_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      mod_q    <= mod_d;
      acc_q    <= acc_d;
      sq_q     <= sq_d;
      bit_q    <= bit_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

`ifdef DH_MODEXP_ERR_CHECK_EN
  // Invalid-modulus tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      bad_q <= bad_d;
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_dh_modexp.sv
// Directed self-checking bench for dh_modexp with hand-computed results.
module tb_dh_modexp;

  localparam int L_EXP = 2146;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base;
  logic [63:0] exp;
  logic [31:0] mod;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        err;

  int tests;
  int fails;

  dh_modexp #(.W(32), .EW(64)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .exp(exp), .mod(mod),
    .busy(busy), .done(done), .result(result), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input logic [63:0] obs, input logic [63:0] expv, input string tag);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Called just after an edge; the following edge samples start.
  task automatic drive_start(input logic [31:0] b, input logic [63:0] e, input logic [31:0] m,
                             input string tag);
    start = 1'b1;
    base  = b;
    exp   = e;
    mod   = m;
    @(posedge clk);
    #1;
    start = 1'b0;
    base  = 32'hDEAD_BEEF;
    exp   = 64'h0123_4567_89AB_CDEF;
    mod   = 32'd99;
    check(busy, 1, {tag, " busy_after_accept"});
  endtask

  task automatic wait_done(input logic [31:0] res_exp, input string tag, input bit repulse);
    int cyc;
    bit seen;
    bit busy_ok;
    cyc     = 0;
    seen    = 1'b0;
    busy_ok = 1'b1;
    while (!seen && cyc < 3000) begin
      if (repulse && cyc == 100) begin
        start = 1'b1;
        base  = 32'd2;
        exp   = 64'd10;
        mod   = 32'd1000;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
      if (done) seen = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    check(seen, 1, {tag, " done_seen"});
    check(cyc, L_EXP, {tag, " latency"});
    check(busy_ok, 1, {tag, " busy_throughout"});
    check(result, res_exp, {tag, " result"});
    check(busy, 0, {tag, " busy_in_done"});
    check(err, 0, {tag, " err"});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    start = 1'b0;
    base  = 32'd0;
    exp   = 64'd0;
    mod   = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check(busy, 0, "reset busy");
    check(done, 0, "reset done");
    check(result, 0, "reset result");
    check(err, 0, "reset err");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    drive_start(32'd5, 64'd3, 32'd17, "t1");
    wait_done(32'd6, "t1", 1'b0);
    @(posedge clk);
    #1;
    check(done, 0, "t1 done_single_pulse");
    repeat (3) @(posedge clk);
    #1;
    check(result, 6, "t1 result_hold");

    drive_start(32'd2, 64'd10, 32'd1000, "t2");
    wait_done(32'd24, "t2", 1'b0);
    // back-to-back: start sampled in the done cycle
    drive_start(32'd20, 64'd1, 32'd17, "t3");
    check(result, 24, "t3 result_held_during_run");
    wait_done(32'd3, "t3", 1'b0);

    repeat (2) @(posedge clk);
    #1;
    drive_start(32'd7, 64'd0, 32'd13, "t4");
    wait_done(32'd1, "t4", 1'b0);

    drive_start(32'd3, 64'hFFFF_FFFF_FFFF_FFFF, 32'd7, "t5");
    wait_done(32'd6, "t5", 1'b0);

    drive_start(32'd2, 64'd4294967290, 32'd4294967291, "t6");
    wait_done(32'd1, "t6", 1'b0);

    drive_start(32'd5, 64'd3, 32'd17, "t7");
    wait_done(32'd6, "t7", 1'b1);
    @(posedge clk);
    #1;
    check(busy, 0, "t7 no_queued_op");

    drive_start(32'd2, 64'd10, 32'd1000, "t8");
    repeat (500) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check(busy, 0, "t8 abort busy");
    check(done, 0, "t8 abort done");
    check(result, 0, "t8 abort result");
    check(err, 0, "t8 abort err");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    drive_start(32'd3, 64'hFFFF_FFFF_FFFF_FFFF, 32'd7, "t9");
    wait_done(32'd6, "t9", 1'b0);

`ifdef DH_MODEXP_ERR_CHECK_EN
    @(posedge clk);
    #1;
    drive_start(32'd5, 64'd3, 32'd1, "e1");
    @(posedge clk);
    #1;
    check(done, 0, "e1 done_early");
    @(posedge clk);
    #1;
    check(done, 1, "e1 done");
    check(err, 1, "e1 err");
    check(result, 0, "e1 result");
    @(posedge clk);
    #1;
    check(done, 0, "e1 done_single_pulse");
    check(err, 1, "e1 err_hold");
    drive_start(32'd5, 64'd3, 32'd17, "e2");
    check(err, 0, "e2 err_cleared");
    wait_done(32'd6, "e2", 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
